// File: rtl/data_mem_arbiter_pkg.sv
// Package for the data_mem arbiter: FSM state encoding, default bus widths,
// port-id constants and the latched-transaction record.
package data_mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  // Fields captured at grant time that steer the rest of the transaction.
  typedef struct packed {
    logic port;  // granted port id
    logic we;    // 1 = write
    logic err;   // misaligned address, no memory access
  } xact_t;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and data_mem.
//   req/we/addr/wdata 0,1 : requester -> arbiter
//   rdata/done/err 0,1    : arbiter -> requester
//   memr/memw/addr/data_in: arbiter -> data_mem
//   mdr                   : data_mem -> arbiter
// slave modport = arbiter side, master modport = requesters + memory side.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0, we0, done0, err0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, done1, err1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic              memr, memw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in, mdr;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mdr,
    output rdata0, done0, err0, rdata1, done1, err1, memr, memw, addr, data_in
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mdr,
    input  rdata0, done0, err0, rdata1, done1, err1, memr, memw, addr, data_in
  );
endinterface

// File: rtl/data_mem_arbiter_rr.sv
// rr_arbiter_2: combinational two-way round-robin grant.
//   req[1:0] : eligible requests
//   ptr      : preferred port when both request
//   gnt[1:0] : one-hot grant (zero when no request)
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin sequencer in front of data_mem.
//   clk, rst : clock, async active-high reset
//   bus      : requester ports 0/1 and data_mem signals (slave modport)
// Each transaction: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE. All outputs are
// registered; done/err/rdata become visible the cycle after RESP.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1  // 1..7
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic              ptr;
  xact_t             cur;
  logic [2:0]        cnt;
  logic              memr_q, memw_q, memr_nxt, memw_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_in_q, rdata0_q, rdata1_q;
  logic              done0_q, done1_q, err0_q, err1_q;

  logic [1:0]        req_elig, gnt;
  logic              win, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // A requester still holds req during its done cycle; masking it there keeps
  // that stale request from being taken as a fresh transaction.
  assign req_elig = {bus.req1 & ~done1_q, bus.req0 & ~done0_q};

  rr_arbiter_2 u_rr (
    .req (req_elig),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign win       = gnt[PORT1];
  assign win_we    = win ? bus.we1    : bus.we0;
  assign win_addr  = win ? bus.addr1  : bus.addr0;
  assign win_wdata = win ? bus.wdata1 : bus.wdata0;

  // Next state plus next memr/memw; the strobes are one-hot by construction.
  always_comb begin
    state_nxt = state;
    memr_nxt  = 1'b0;
    memw_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          if (win_addr[0]) begin
            state_nxt = RESP;
          end else begin
            state_nxt = ACCESS;
            memw_nxt  = win_we;
            memr_nxt  = ~win_we;
          end
        end
      end
      ACCESS: begin
        if (cur.we) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          memr_nxt  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nxt = RESP;
        else             memr_nxt  = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= PORT0;
      cur       <= '0;
      cnt       <= '0;
      memr_q    <= 1'b0;
      memw_q    <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      memr_q  <= memr_nxt;
      memw_q  <= memw_nxt;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            cur <= '{port: win, we: win_we, err: win_addr[0]};
            // Misaligned requests never touch the memory bus.
            if (!win_addr[0]) begin
              addr_q    <= win_addr;
              data_in_q <= win_wdata;
            end
          end
        end
        ACCESS: if (!cur.we) cnt <= LAT_LOAD;
        WAIT: begin
          if (cnt == 3'd0) begin
            if (cur.port == PORT1) rdata1_q <= bus.mdr;
            else                   rdata0_q <= bus.mdr;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (cur.port == PORT1) begin
            done1_q <= 1'b1;
            err1_q  <= cur.err;
          end else begin
            done0_q <= 1'b1;
            err0_q  <= cur.err;
          end
          ptr <= other_port(cur.port);
        end
        default: ;
      endcase
    end
  end

  assign bus.memr    = memr_q;
  assign bus.memw    = memw_q;
  assign bus.addr    = addr_q;
  assign bus.data_in = data_in_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: unit 0 built with RD_LAT=1, unit 1 with RD_LAT=3,
// each with its own byte-banked data_mem model. Expected completions are queued
// when a request is driven and compared when done is seen.
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_u   [2];
  logic          req_d   [2][2];
  logic          we_d    [2][2];
  logic [AW-1:0] addr_d  [2][2];
  logic [DW-1:0] wdata_d [2][2];
  logic          done_s  [2][2];
  logic          err_s   [2][2];
  logic [DW-1:0] rdata_s [2][2];
  logic          memr_s  [2];
  logic          memw_s  [2];
  logic [AW-1:0] maddr_s [2];
  logic [DW-1:0] mdin_s  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nmemr [2];
  int nmemw [2];
  logic [AW-1:0] wr_addr [2];
  logic [DW-1:0] wr_data [2];
  logic [DW-1:0] last_rd [2][2];

  typedef struct {
    int            u;
    int            p;
    int            issue;
    int            lat;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  for (genvar u = 0; u < 2; u++) begin : g_u
    localparam int LAT = (u == 0) ? 1 : 3;
    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst_u[u]),
      .bus (bus)
    );
    assign bus.req0   = req_d[u][0];
    assign bus.we0    = we_d[u][0];
    assign bus.addr0  = addr_d[u][0];
    assign bus.wdata0 = wdata_d[u][0];
    assign bus.req1   = req_d[u][1];
    assign bus.we1    = we_d[u][1];
    assign bus.addr1  = addr_d[u][1];
    assign bus.wdata1 = wdata_d[u][1];
    assign done_s[u][0]  = bus.done0;
    assign done_s[u][1]  = bus.done1;
    assign err_s[u][0]   = bus.err0;
    assign err_s[u][1]   = bus.err1;
    assign rdata_s[u][0] = bus.rdata0;
    assign rdata_s[u][1] = bus.rdata1;
    assign memr_s[u]  = bus.memr;
    assign memw_s[u]  = bus.memw;
    assign maddr_s[u] = bus.addr;
    assign mdin_s[u]  = bus.data_in;

    // data_mem model: even/odd byte banks, read data after LAT cycles.
    logic [7:0]    mem_e [0:32767];
    logic [7:0]    mem_o [0:32767];
    logic [DW-1:0] rd_pipe [8];
    always @(posedge clk) begin
      if (bus.memw) begin
        mem_e[bus.addr[15:1]] <= bus.data_in[7:0];
        mem_o[bus.addr[15:1]] <= bus.data_in[15:8];
      end
      rd_pipe[0] <= bus.memr ? {mem_o[bus.addr[15:1]], mem_e[bus.addr[15:1]]} : 16'hDEAD;
      for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mdr = rd_pipe[LAT-1];
  end

  // Monitor: invariants every cycle, scoreboard pop on each done.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d memr_and_memw", u), 32'(memr_s[u] & memw_s[u]), 0);
      chk($sformatf("u%0d done0_and_done1", u), 32'(done_s[u][0] & done_s[u][1]), 0);
      if (memr_s[u]) nmemr[u]++;
      if (memw_s[u]) begin
        nmemw[u]++;
        wr_addr[u] = maddr_s[u];
        wr_data[u] = mdin_s[u];
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("u%0d p%0d err_without_done", u, p), 32'(err_s[u][p] & ~done_s[u][p]), 0);
        if (done_s[u][p]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("u%0d p%0d unexpected_done", u, p), 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("done_unit_port", 32'(u * 2 + p), 32'(mon_e.u * 2 + mon_e.p));
            chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            chk("err", 32'(err_s[u][p]), 32'(mon_e.err));
            chk("rdata", 32'(rdata_s[u][p]), 32'(mon_e.rdata));
          end
        end
      end
    end
  end

  function automatic int exp_lat(input int u, input logic we, input logic [AW-1:0] a);
    if (a[0]) return 2;
    if (we)   return 3;
    return 3 + ((u == 0) ? 1 : 3);
  endfunction

  task automatic push(input int u, input int p, input int issue, input int lat,
                      input logic err, input logic [DW-1:0] rd);
    exp_t e;
    e.u = u; e.p = p; e.issue = issue; e.lat = lat; e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int u, input int p);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done_s[u][p] && n < 40);
    if (!done_s[u][p]) chk($sformatf("u%0d p%0d done_timeout", u, p), 0, 1);
  endtask

  // One complete transaction; rd is the data a good aligned read returns.
  task automatic txn(input int u, input int p, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    @(negedge clk);
    if (!we && !a[0]) last_rd[u][p] = rd;
    push(u, p, cyc, exp_lat(u, we, a), a[0], last_rd[u][p]);
    req_d[u][p] = 1'b1; we_d[u][p] = we; addr_d[u][p] = a; wdata_d[u][p] = wd;
    wait_done(u, p);
    @(negedge clk);
    req_d[u][p] = 1'b0;
  endtask

  task automatic clr_cnt(input int u);
    nmemr[u] = 0; nmemw[u] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst_u[u] = 1'b1;
      nmemr[u] = 0; nmemw[u] = 0;
      for (int p = 0; p < 2; p++) begin
        req_d[u][p] = 1'b0; we_d[u][p] = 1'b0; addr_d[u][p] = '0; wdata_d[u][p] = '0;
        last_rd[u][p] = '0;
      end
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst_memr", u), 32'(memr_s[u]), 0);
      chk($sformatf("u%0d rst_memw", u), 32'(memw_s[u]), 0);
      chk($sformatf("u%0d rst_addr", u), 32'(maddr_s[u]), 0);
      chk($sformatf("u%0d rst_data_in", u), 32'(mdin_s[u]), 0);
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("u%0d p%0d rst_done", u, p), 32'(done_s[u][p]), 0);
        chk($sformatf("u%0d p%0d rst_err", u, p), 32'(err_s[u][p]), 0);
        chk($sformatf("u%0d p%0d rst_rdata", u, p), 32'(rdata_s[u][p]), 0);
      end
    end
    rst_u[0] = 1'b0; rst_u[1] = 1'b0;

    // 1: port 0 write
    clr_cnt(0);
    txn(0, 0, 1'b1, 16'h2340, 16'hABCD, '0);
    chk("t1_memw_cycles", 32'(nmemw[0]), 1);
    chk("t1_memr_cycles", 32'(nmemr[0]), 0);
    chk("t1_addr", 32'(wr_addr[0]), 32'h2340);
    chk("t1_data_in", 32'(wr_data[0]), 32'hABCD);
    chk("t1_mem_even", 32'(g_u[0].mem_e[15'h11A0]), 32'hCD);
    chk("t1_mem_odd", 32'(g_u[0].mem_o[15'h11A0]), 32'hAB);

    // 2: port 0 read back
    clr_cnt(0);
    txn(0, 0, 1'b0, 16'h2340, '0, 16'hABCD);
    chk("t2_memr_cycles", 32'(nmemr[0]), 2);
    chk("t2_memw_cycles", 32'(nmemw[0]), 0);

    // 3: both ports requesting out of reset, writes, alternate grants
    @(negedge clk);
    rst_u[0] = 1'b1;
    req_d[0][0] = 1'b1; we_d[0][0] = 1'b1; addr_d[0][0] = 16'h0100; wdata_d[0][0] = 16'hA5A5;
    req_d[0][1] = 1'b1; we_d[0][1] = 1'b1; addr_d[0][1] = 16'h0200; wdata_d[0][1] = 16'h5A5A;
    last_rd[0][0] = '0; last_rd[0][1] = '0;
    @(negedge clk);
    rst_u[0] = 1'b0;
    push(0, 0, cyc, 3, 1'b0, '0);
    push(0, 1, cyc, 6, 1'b0, '0);
    push(0, 0, cyc, 9, 1'b0, '0);
    push(0, 1, cyc, 12, 1'b0, '0);
    wait_done(0, 0);
    wait_done(0, 1);
    wait_done(0, 0);
    @(negedge clk); req_d[0][0] = 1'b0;
    wait_done(0, 1);
    @(negedge clk); req_d[0][1] = 1'b0;

    // 4: port 1 aligned read, then misaligned read keeps rdata1
    txn(0, 1, 1'b0, 16'h0200, '0, 16'h5A5A);
    clr_cnt(0);
    txn(0, 1, 1'b0, 16'h2341, '0, '0);
    chk("t4_memr_cycles", 32'(nmemr[0]), 0);
    chk("t4_memw_cycles", 32'(nmemw[0]), 0);

    // 5: reset while in WAIT aborts the read
    @(negedge clk);
    req_d[0][0] = 1'b1; we_d[0][0] = 1'b0; addr_d[0][0] = 16'h2340;
    @(posedge clk); @(posedge clk); #1;
    chk("t5_memr_in_wait", 32'(memr_s[0]), 1);
    #2 rst_u[0] = 1'b1;
    #1 chk("t5_memr_async_drop", 32'(memr_s[0]), 0);
    req_d[0][0] = 1'b0;
    last_rd[0][0] = '0; last_rd[0][1] = '0;
    @(negedge clk);
    rst_u[0] = 1'b0;
    repeat (8) @(negedge clk);
    txn(0, 0, 1'b0, 16'h2340, '0, 16'hABCD);

    // 6: RD_LAT=3 unit
    txn(1, 0, 1'b1, 16'h0010, 16'h1234, '0);
    clr_cnt(1);
    txn(1, 1, 1'b0, 16'h0010, '0, 16'h1234);
    chk("t6_memr_cycles", 32'(nmemr[1]), 4);
    txn(1, 0, 1'b0, 16'h0011, '0, '0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
